// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol state encoding and the bit values used on
// the wire for the R/W flag and the acknowledge slot.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the clk domain and derives single-cycle SCL edge strobes
// plus START/STOP conditions from the synchronized values only.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;

  // NOTE: non-blocking assignments keep every flop of the shift chain sampling
  // the pre-edge value, so the chain really is two stages deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff   <= {scl_ff[0], scl};
      sda_ff   <= {sda_ff[0], sda};
      scl_prev <= scl_ff[1];
      sda_prev <= sda_ff[1];
    end
  end

  assign sda_s     = sda_ff[1];
  assign scl_rise  =  scl_ff[1] & ~scl_prev;
  assign scl_fall  = ~scl_ff[1] &  scl_prev;
  // SDA may only move while SCL is low, so an SDA edge under a stable-high SCL
  // is a bus condition rather than data.
  assign start_det = scl_ff[1] & scl_prev &  sda_prev & ~sda_ff[1];
  assign stop_det  = scl_ff[1] & scl_prev & ~sda_prev &  sda_ff[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target backed by a small register file: write pointer, burst writes,
// burst reads with auto-increment, and a host-side read/observe port.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h2A,
  parameter int         NUM_REGS      = 16,
  localparam int        PTR_W         = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             scl,
  inout  wire              sda,
  input  logic [PTR_W-1:0] host_rd_addr,
  output logic [7:0]       host_rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  i2c_state_e       state;
  logic [6:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [PTR_W-1:0] ptr;
  logic             ack_phase;
  logic             rw;
  logic             sda_oe;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       rx_byte;
  logic             sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda          = sda_oe ? 1'b0 : 1'bz;
  assign host_rd_data = regs[host_rd_addr];
  assign rx_byte      = {shreg, sda_s};

  always_ff @(posedge clk) begin
    wr_strobe <= 1'b0;
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      ack_phase <= 1'b0;
      rw        <= I2C_RW_WRITE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      // NOTE: the file is cleared in reset because its contents are visible on
      // host_rd_data; this rules out block-RAM inference, fine at this depth.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (stop_det) begin
      state  <= ST_IDLE;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else if (start_det) begin
      state   <= ST_ADDR;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else if (scl_fall && !en && !(state inside {ST_IDLE, ST_IGNORE})) begin
      sda_oe <= 1'b0;
      state  <= ST_IGNORE;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_phase <= 1'b0;
              case (state)
                ST_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDRESS && en) begin
                    busy  <= 1'b1;
                    rw    <= rx_byte[0];
                    state <= ST_ADDR_ACK;
                  end else begin
                    busy  <= 1'b0;
                    state <= ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  ptr   <= rx_byte[PTR_W-1:0];
                  state <= ST_PTR_ACK;
                end
                default: begin
                  regs[ptr] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= rx_byte;
                  state     <= ST_WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First fall opens the ACK slot, second fall closes it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase <= 1'b1;
              sda_oe    <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_ADDR_ACK && rw == I2C_RW_READ) begin
                shreg  <= regs[ptr][6:0];
                sda_oe <= ~regs[ptr][7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                if (state == ST_WDATA_ACK) ptr <= ptr + 1'b1;
                state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              state     <= ST_RDATA_ACK;
            end else begin
              sda_oe <= ~shreg[6];
              shreg  <= {shreg[5:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr       <= ptr + 1'b1;
              ack_phase <= 1'b1;
            end else begin
              state <= ST_IGNORE;
            end
          end else if (scl_fall && ack_phase) begin
            shreg   <= regs[ptr][6:0];
            sda_oe  <= ~regs[ptr][7];
            bit_cnt <= '0;
            state   <= ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
